// File: rtl/top_datapath.sv
// Accumulator datapath for a BIP-style processor.
// Holds the 16-bit accumulator, selects its load source (memory, sign-extended
// immediate, or add/sub ALU result) and drives the data-memory address/write data.
module top_datapath #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OPER_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [OPER_W-1:0] i_signal,
  input  logic [DATA_W-1:0] i_Out_Data,
  input  logic [1:0]        i_selA,
  input  logic              i_selB,
  input  logic              i_WrAcc,
  input  logic              i_OP,
  output logic [OPER_W-1:0] o_Addr,
  output logic [DATA_W-1:0] o_In_Data
);

  typedef enum logic [1:0] {
    SRC_MEM  = 2'b00,
    SRC_IMM  = 2'b01,
    SRC_ALU  = 2'b10,
    SRC_HOLD = 2'b11
  } acc_src_e;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] alu_res;
  acc_src_e          src_sel;
  alu_op_e           alu_op;

  assign src_sel = acc_src_e'(i_selA);
  assign alu_op  = alu_op_e'(i_OP);

  // Sign-extend the operand field to the data width.
  always_comb begin
    ext = {{(DATA_W - OPER_W){i_signal[OPER_W-1]}}, i_signal};
  end

  // ALU: select second operand, then add or subtract modulo 2^DATA_W.
  always_comb begin
    opnd_b  = i_selB ? ext : i_Out_Data;
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = acc_q + opnd_b;
      ALU_SUB: alu_res = acc_q - opnd_b;
      default: alu_res = acc_q + opnd_b;
    endcase
  end

  // Accumulator load-source mux and write-enable gating.
  always_comb begin
    acc_d = acc_q;
    if (i_WrAcc) begin
      case (src_sel)
        SRC_MEM:  acc_d = i_Out_Data;
        SRC_IMM:  acc_d = ext;
        SRC_ALU:  acc_d = alu_res;
        SRC_HOLD: acc_d = acc_q;
        default:  acc_d = acc_q;
      endcase
    end
  end

  // Accumulator register; reset takes priority over any write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_In_Data = acc_q;
  assign o_Addr    = i_signal;

endmodule

// File: tb/tb_top_datapath.sv
// Self-checking bench for top_datapath: directed plan steps followed by
// randomized cycles, checked against an arithmetic reference model.
module tb_top_datapath;

  logic        clk;
  logic        rst;
  logic [10:0] sig;
  logic [15:0] od;
  logic [1:0]  selA;
  logic        selB;
  logic        wr;
  logic        op;
  logic [10:0] o_Addr;
  logic [15:0] o_In_Data;

  int errors = 0;
  int checks = 0;
  int mdl    = 0;

  top_datapath #(.DATA_W(16), .OPER_W(11)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_signal   (sig),
    .i_Out_Data (od),
    .i_selA     (selA),
    .i_selB     (selB),
    .i_WrAcc    (wr),
    .i_OP       (op),
    .o_Addr     (o_Addr),
    .o_In_Data  (o_In_Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wrap16(input int v);
    return ((v % 65536) + 65536) % 65536;
  endfunction

  // Model: ACC value after the next edge, from the spec's rules in plain integers.
  function automatic int model_next();
    int ext, b, res;
    ext = int'(sig);
    if (ext >= 1024) ext = ext - 2048;
    b   = selB ? ext : int'(od);
    res = op ? mdl - b : mdl + b;
    if (rst) return 0;
    if (!wr) return mdl;
    case (selA)
      2'd0:    return int'(od);
      2'd1:    return wrap16(ext);
      2'd2:    return wrap16(res);
      default: return mdl;
    endcase
  endfunction

  task automatic set_in(input logic r, input logic [10:0] s, input logic [15:0] d,
                        input logic [1:0] a, input logic b, input logic w, input logic o);
    rst = r; sig = s; od = d; selA = a; selB = b; wr = w; op = o;
  endtask

  task automatic check_acc(input string tag, input int exp);
    checks++;
    assert (o_In_Data === 16'(exp))
      else begin
        errors++;
        $error("FAIL %s: o_In_Data=%h expected %h", tag, o_In_Data, 16'(exp));
      end
  endtask

  task automatic check_addr(input string tag);
    checks++;
    assert (o_Addr === sig)
      else begin
        errors++;
        $error("FAIL %s: o_Addr=%h expected %h", tag, o_Addr, sig);
      end
  endtask

  // One clock edge: predict, advance, then sample away from the edge.
  task automatic step(input string tag);
    int nxt;
    nxt = model_next();
    @(posedge clk);
    #1;
    mdl = nxt;
    check_acc(tag, mdl);
    check_addr(tag);
  endtask

  initial begin
    set_in(1'b1, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    step("init_reset");

    // 1. Reset overrides a pending write
    set_in(1'b0, 11'h000, 16'h1234, 2'b00, 1'b0, 1'b1, 1'b0);
    step("preload_1234");
    check_acc("preload_const", 16'h1234);
    set_in(1'b1, 11'h005, 16'h1234, 2'b01, 1'b0, 1'b1, 1'b0);
    step("reset_priority");
    check_acc("reset_const", 16'h0000);

    // 2. 7 + 10
    set_in(1'b0, 11'd7, 16'h0000, 2'b01, 1'b0, 1'b1, 1'b0);
    step("imm_7");
    check_acc("imm_7_const", 16'h0007);
    set_in(1'b0, 11'd7, 16'd10, 2'b10, 1'b0, 1'b1, 1'b0);
    step("add_10");
    check_acc("add_10_const", 16'h0011);

    // 3. Negative immediate then subtract immediate
    set_in(1'b0, 11'h7FF, 16'h0000, 2'b01, 1'b0, 1'b1, 1'b0);
    step("imm_neg1");
    check_acc("imm_neg1_const", 16'hFFFF);
    set_in(1'b0, 11'd3, 16'h0000, 2'b10, 1'b1, 1'b1, 1'b1);
    step("sub_3");
    check_acc("sub_3_const", 16'hFFFC);

    // 4. Wrap-around both directions
    set_in(1'b0, 11'h7FF, 16'h0000, 2'b01, 1'b0, 1'b1, 1'b0);
    step("load_ffff");
    set_in(1'b0, 11'h000, 16'h0002, 2'b10, 1'b0, 1'b1, 1'b0);
    step("wrap_add");
    check_acc("wrap_add_const", 16'h0001);
    set_in(1'b0, 11'h000, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0);
    step("load_zero");
    set_in(1'b0, 11'h000, 16'h0001, 2'b10, 1'b0, 1'b1, 1'b1);
    step("wrap_sub");
    check_acc("wrap_sub_const", 16'hFFFF);

    // 5. Write-enable gating and hold select
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 11'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      step("wr_gated");
    end
    check_acc("wr_gated_const", 16'hFFFF);
    set_in(1'b0, 11'h123, 16'h5555, 2'b11, 1'b1, 1'b1, 1'b0);
    step("hold_sel");
    check_acc("hold_sel_const", 16'hFFFF);

    // 6. Memory load and address passthrough
    set_in(1'b0, 11'h3A5, 16'hBEEF, 2'b00, 1'b0, 1'b1, 1'b0);
    #1;
    check_addr("addr_comb");
    step("mem_load");
    check_acc("mem_load_const", 16'hBEEF);

    // Randomized traffic, with occasional mid-sequence resets
    for (int i = 0; i < 300; i++) begin
      set_in(($urandom_range(0, 31) == 0), 11'($urandom), 16'($urandom), 2'($urandom),
             1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/top_datapath.md
Name: top_datapath

Overview:
Accumulator-based datapath of a BIP-style processor; sits between the control unit, which drives the select, write and opcode signals, and the data memory.
- Holds a 16-bit accumulator (ACC).
- Selects the ACC load source: data memory, sign-extended immediate, or ALU result.
- Add/subtract ALU computes ACC ± operand.
- Drives the memory address (operand field) and the memory write data (ACC).

Parameters:
DATA_W, 16, accumulator / ALU / memory data width
OPER_W, 11, instruction operand field width (immediate and data address)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_signal  input  OPER_W  instruction operand: immediate value or data-memory address
i_Out_Data  input  DATA_W  data read from data memory
i_selA  input  2  ACC load source select
i_selB  input  1  ALU second-operand select
i_WrAcc  input  1  accumulator write enable
i_OP  input  1  ALU opcode: 0 add, 1 subtract
o_Addr  output  OPER_W  data memory address
o_In_Data  output  DATA_W  data to write into data memory

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst. Only ACC is registered; everything else is combinational.
- Reset: on a rising edge with i_rst=1, ACC <= 0. Reset has priority over i_WrAcc. A reset mid-sequence discards any pending write.
- After reset, o_In_Data = 0. o_Addr always follows i_signal, so it has no reset value.
- Sign extension: EXT = i_signal sign-extended from OPER_W to DATA_W (bit 10 replicated into bits 15:11).
- Operand B mux: i_selB=0 -> i_Out_Data; i_selB=1 -> EXT.
- ALU, combinational:
  - i_OP=0: RES = ACC + B.
  - i_OP=1: RES = ACC - B.
  - Result is truncated to DATA_W (modulo 2^16 wrap). There are no carry or overflow outputs.
- ACC source mux, selected by i_selA:
  - 00 -> i_Out_Data
  - 01 -> EXT
  - 10 -> RES
  - 11 -> ACC (hold; a write with 11 leaves ACC unchanged)
- ACC write: on a rising edge with i_rst=0 and i_WrAcc=1, ACC <= mux output. With i_WrAcc=0, ACC holds regardless of the other inputs.
- Latency: one clock edge from write enable to the new ACC value. ALU and mux paths settle within the same cycle.
- When RES is loaded, it is computed from the pre-edge ACC (read-modify-write within one cycle).
- Outputs:
  - o_In_Data = ACC (registered value).
  - o_Addr = i_signal (combinational passthrough).
- No X propagation from undriven selects: every select value is defined above.

Test Plan:
1. Reset: ACC preloaded to 0x1234, then i_rst=1 with i_WrAcc=1, i_selA=01 at an edge -> o_In_Data = 0x0000 after that edge.
2. Immediate load then add (7 + 10):
   - First step: i_signal=7, i_selA=01, i_WrAcc pulsed for one edge -> o_In_Data = 0x0007.
   - Second step: i_Out_Data=10, i_selB=0, i_OP=0, i_selA=10, i_WrAcc pulsed for one edge -> o_In_Data = 0x0011; o_Addr tracks i_signal throughout.
3. Subtract and negative immediate:
   - First step: load i_signal=11'h7FF (=-1) -> ACC = 0xFFFF.
   - Second step: i_selB=1, i_signal=3, i_OP=1, i_selA=10, write -> ACC = 0xFFFC.
4. Wrap-around: ACC=0xFFFF, add i_Out_Data=0x0002 -> ACC = 0x0001. ACC=0x0000, subtract 1 -> ACC = 0xFFFF.
5. Write enable gating: i_WrAcc=0 while toggling i_selA, i_selB, i_OP and the data inputs for 10 cycles -> ACC unchanged. i_selA=11 with i_WrAcc=1 -> ACC unchanged.
6. Memory load: i_Out_Data=0xBEEF, i_selA=00, write -> o_In_Data = 0xBEEF. Also i_signal=0x3A5 -> o_Addr = 0x3A5 in the same cycle.
